// File: rtl/cargador_pkg.sv
// rtl/cargador_pkg.sv - shared types and sizing helpers for the register-bank serial loader
//
// Purpose: loader FSM state encoding, default word geometry and the
// index-width helper used to size WriteReg and the index counter.
// Ports: none (package).
package cargador_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    RECIBE  = 2'd1,
    ESCRIBE = 2'd2,
    FIN     = 2'd3
  } estado_t;

  localparam int ANCHO_DEF         = 32;
  localparam int BYTES_POR_PALABRA = ANCHO_DEF / 8;

  // Width needed to index n items; never below one bit so a
  // single-entry configuration still has a legal vector.
  function automatic int ancho_indice(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bytes_por_palabra(input int ancho);
    return ancho / 8;
  endfunction

endpackage

// File: rtl/cargador_registros_ensamblador.sv
// rtl/cargador_registros_ensamblador.sv - byte counter and little-endian word register
//
// Purpose: packs incoming bytes into one ANCHO-bit word, byte n landing in
// bits [8n+7:8n].
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cargar            store dato at the current byte position
//   limpiar           return the byte counter to position 0
//   dato[7:0]         byte to store
//   palabra           assembled word register
//   palabra_completa  high when this cargar fills the last byte position
module ensamblador_palabra
  import cargador_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cargar,
  input  logic             limpiar,
  input  logic [7:0]       dato,
  output logic [ANCHO-1:0] palabra,
  output logic             palabra_completa
);

  localparam int BYTES = bytes_por_palabra(ANCHO);
  localparam int CW    = ancho_indice(BYTES);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0] palabra_q, palabra_d;
  logic             completa;

  always_comb begin
    cnt_d     = cnt_q;
    palabra_d = palabra_q;
    completa  = cargar && (cnt_q == CW'(BYTES - 1));
    if (limpiar) begin
      cnt_d = '0;
    end else if (cargar) begin
      palabra_d[8*cnt_q +: 8] = dato;
      // The counter parks on the last position; only limpiar brings it
      // back to 0, so it can never wrap on its own.
      if (!completa) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      palabra_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      palabra_q <= palabra_d;
    end
  end

  assign palabra          = palabra_q;
  assign palabra_completa = completa;

endmodule

// File: rtl/cargador_registros.sv
// rtl/cargador_registros.sv - serial byte-stream loader driving the register bank write port
//
// Purpose: after Inicio, accepts bytes over DatoValido/DatoListo, packs each
// group of ANCHO/8 bytes into a word and writes registers 0..NUM_REGS-1 in
// order, one single-cycle write each.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   Inicio                start pulse, honoured only when idle
//   DatoEntrada[7:0]      stream byte
//   DatoValido            source offers a byte
//   DatoListo             loader takes the byte this cycle
//   WriteReg, WriteData   write-port index and word (held outside writes)
//   Regwrite              one-cycle write strobe
//   Ocupado               session in progress
//   Terminado             one-cycle pulse at session end
module cargador_registros
  import cargador_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int ANCHO       = 32,
  parameter int SALTAR_CERO = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              Inicio,
  input  logic [7:0]                        DatoEntrada,
  input  logic                              DatoValido,
  output logic                              DatoListo,
  output logic [ancho_indice(NUM_REGS)-1:0] WriteReg,
  output logic [ANCHO-1:0]                  WriteData,
  output logic                              Regwrite,
  output logic                              Ocupado,
  output logic                              Terminado
);

  localparam int IW = ancho_indice(NUM_REGS);

  estado_t          estado_q, estado_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    write_reg_q, write_reg_d;
  logic [ANCHO-1:0] write_data_q, write_data_d;

  logic             cargar, limpiar, completa, ultimo;
  logic [ANCHO-1:0] palabra;

  assign ultimo  = (idx_q == IW'(NUM_REGS - 1));
  assign cargar  = (estado_q == RECIBE) && DatoValido;
  // Counter is cleared both at session start and after every write.
  assign limpiar = ((estado_q == REPOSO) && Inicio) || (estado_q == ESCRIBE);

  ensamblador_palabra #(
    .ANCHO(ANCHO)
  ) u_ensamblador (
    .clk              (clk),
    .rst_n            (rst_n),
    .cargar           (cargar),
    .limpiar          (limpiar),
    .dato             (DatoEntrada),
    .palabra          (palabra),
    .palabra_completa (completa)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:  if (Inicio) estado_d = RECIBE;
      RECIBE:  if (completa) estado_d = ESCRIBE;
      ESCRIBE: estado_d = ultimo ? FIN : RECIBE;
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Outputs decoded from state; the write port shows the live index/word
  // during ESCRIBE and the captured copy of the last write otherwise,
  // because the assembler starts overwriting bytes right after the write.
  always_comb begin
    DatoListo = (estado_q == RECIBE);
    Ocupado   = (estado_q != REPOSO);
    Terminado = (estado_q == FIN);
    Regwrite  = (estado_q == ESCRIBE) && !((SALTAR_CERO != 0) && (idx_q == '0));
    WriteReg  = (estado_q == ESCRIBE) ? idx_q   : write_reg_q;
    WriteData = (estado_q == ESCRIBE) ? palabra : write_data_q;
  end

  // Index counter and write-port hold registers
  always_comb begin
    idx_d        = idx_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if ((estado_q == REPOSO) && Inicio) begin
      idx_d = '0;
    end else if (estado_q == ESCRIBE) begin
      write_reg_d  = idx_q;
      write_data_d = palabra;
      if (!ultimo) begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      idx_q        <= idx_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: doc/cargador_registros.md
# cargador_registros

Serial loader that fills the register bank through its write port (WriteReg, WriteData, Regwrite). It is the writer side of that port: it replaces file-based preloading with a runtime byte stream. After an `Inicio` pulse it accepts bytes over a valid/ready handshake, packs every four bytes into a 32-bit word, and issues one single-cycle write per register, from index 0 upward, until all registers are loaded. It sits between the debug/boot byte source and the register bank write port, and is muxed with the datapath writeback.

## Interface
Parameters:
- `NUM_REGS`, 32: number of registers loaded per session; index width is `$clog2(NUM_REGS)` (5).
- `ANCHO`, 32: data word width; must be a multiple of 8.
- `SALTAR_CERO`, 1: when 1, the word for register 0 is consumed but no write is issued ($zero stays hard-wired).

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `Inicio`  in  1  — start pulse; sampled only in REPOSO.
- `DatoEntrada`  in  8  — stream byte.
- `DatoValido`  in  1  — source has a byte on `DatoEntrada`.
- `DatoListo`  out  1  — loader accepts a byte this cycle.
- `WriteReg`  out  5  — destination register index.
- `WriteData`  out  ANCHO  — word to write.
- `Regwrite`  out  1  — write strobe; high for exactly one cycle per register write.
- `Ocupado`  out  1  — high while state ≠ REPOSO.
- `Terminado`  out  1  — one-cycle pulse when the session completes.

## Operation
- States: REPOSO → RECIBE → ESCRIBE → (RECIBE | FIN) → REPOSO.
- **REPOSO:** `DatoListo` = 0. When `Inicio` = 1: clear index and byte counter, then go to RECIBE.
- **RECIBE:** `DatoListo` = 1.
  - A byte is accepted on `DatoValido && DatoListo` and placed little-endian: byte n goes to bits [8n+7:8n].
  - When byte `ANCHO/8-1` is accepted, go to ESCRIBE.
  - When `DatoValido` = 0, the state holds and nothing changes.
- **ESCRIBE:** `DatoListo` = 0.
  - `Regwrite` = 1, except when index == 0 and `SALTAR_CERO` = 1.
  - `WriteReg` = index; `WriteData` = the assembled word.
  - If index == `NUM_REGS-1`, go to FIN. Otherwise increment the index, clear the byte counter, and go to RECIBE.
- **FIN:** `Terminado` = 1 for one cycle, then go to REPOSO.
- **Boundaries:**
  - `Inicio` outside REPOSO is ignored.
  - A byte offered while `DatoListo` = 0 is not consumed; the source must hold it.
  - The index never wraps within a session.
  - The byte counter wraps 3→0 only via ESCRIBE.
- **Reset:** all state is cleared, including mid-session. Partially assembled words are discarded and no write is issued. The next session starts at register 0.

## Timing
- Reset values: `DatoListo`, `Regwrite`, `Ocupado`, `Terminado` = 0; `WriteReg` = 0; `WriteData` = 0.
- All outputs are registered or decoded from state (Moore). `WriteReg`/`WriteData` hold their last value outside ESCRIBE.
- Cycle timeline with `Inicio` sampled at edge 0 and continuous `DatoValido`:
  - RECIBE starts in cycle 1.
  - The write for register k occurs in cycle 5(k+1).
  - The last write occurs in cycle 160.
  - `Terminado` is high in cycle 161.
  - REPOSO is reached in cycle 162.
  - `Ocupado` is high in cycles 1–161.
- Minimum cost is 5 cycles per register. Each cycle with `DatoValido` = 0 in RECIBE adds exactly one cycle.
- Assertion: `Regwrite` is never high for two consecutive cycles.

## Structure
- Package `cargador_pkg` holds:
  - the state enum (REPOSO, RECIBE, ESCRIBE, FIN);
  - `BYTES_POR_PALABRA = ANCHO/8`;
  - the index width function.
- Sub-module `ensamblador_palabra`: byte counter plus little-endian word register, with `cargar`/`limpiar` inputs and a `palabra_completa` output. The FSM, index counter and write-port outputs stay in the top module.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 2 cycles mid-stream. Required: all outputs 0 and `DatoListo` = 0 one edge later.
2. **Full load:** `Inicio`, then bytes 0x00…0x7F continuously.
   - No write to register 0.
   - Register 1 ← 0x07060504 in cycle 10.
   - Register 31 ← 0x7F7E7D7C in cycle 160.
   - `Terminado` in cycle 161.
3. **Backpressure:** `DatoValido` toggled every other cycle with the same bytes. Required: identical write data and order, with each write delayed by its gap count, and no lost or duplicated byte.
4. **`Inicio` while busy:** pulse `Inicio` at cycle 50. Required: no restart, with write order and timing identical to test 2.
5. **Reset mid-session:** assert `rst_n` = 0 in cycle 27, then restart with bytes 0xA0….
   - `Regwrite` = 0 from the next edge.
   - After restart, register 1 ← 0xA7A6A5A4.
6. **`SALTAR_CERO` = 0:** run the test 2 stimulus. Required: `Regwrite` in cycle 5 with `WriteReg` = 0 and `WriteData` = 0x03020100.
